// File: rtl/mul_share_arbiter.sv
// Round-robin front end that shares one pipelined 32x32 multiplier among
// NUM_REQ requesters and returns tagged products on a valid/ready channel.
module mul_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int MUL_LAT = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*32-1:0] req_a,
    input  logic [NUM_REQ*32-1:0] req_b,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  mul_ce,
    output logic [31:0]           mul_din0,
    output logic [31:0]           mul_din1,
    input  logic [63:0]           mul_dout,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [63:0]           rsp_data,
    output logic                  busy
);

    logic [ID_W-1:0]    lastGrant;
    logic [ID_W-1:0]    grantIdx;
    logic               grantFound;
    int                 searchIdx;
    logic [31:0]        holdA;
    logic [31:0]        holdB;
    logic [MUL_LAT-1:0] stageV;
    logic [ID_W-1:0]    stageId [MUL_LAT];

    assign mul_ce = !rsp_valid || rsp_ready;

    // Rotating-priority search starting just after the last granted index;
    // reset_n gates it so no grant is visible while reset is held.
    always_comb begin
        grantFound = 1'b0;
        grantIdx   = '0;
        searchIdx  = 0;
        if (mul_ce && reset_n) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                searchIdx = (int'(lastGrant) + k) % NUM_REQ;
                if (!grantFound && req_valid[searchIdx]) begin
                    grantFound = 1'b1;
                    grantIdx   = ID_W'(searchIdx);
                end
            end
        end
    end

    assign req_ready = grantFound ? (NUM_REQ'(1) << grantIdx) : '0;

    // Operands hold their last granted value when idle, so the multiplier
    // inputs never float or glitch between transfers.
    assign mul_din0 = grantFound ? req_a[32*int'(grantIdx) +: 32] : holdA;
    assign mul_din1 = grantFound ? req_b[32*int'(grantIdx) +: 32] : holdB;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lastGrant <= ID_W'(NUM_REQ - 1);
            holdA     <= '0;
            holdB     <= '0;
        end else if (grantFound) begin
            lastGrant <= grantIdx;
            holdA     <= mul_din0;
            holdB     <= mul_din1;
        end
    end

    // Tag pipeline mirrors the multiplier's register stages and freezes with ce.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stageV <= '0;
            for (int i = 0; i < MUL_LAT; i++) begin
                stageId[i] <= '0;
            end
        end else if (mul_ce) begin
            stageV[0]  <= grantFound;
            stageId[0] <= grantIdx;
            for (int i = 1; i < MUL_LAT; i++) begin
                stageV[i]  <= stageV[i-1];
                stageId[i] <= stageId[i-1];
            end
        end
    end

    assign rsp_valid = stageV[MUL_LAT-1];
    assign rsp_id    = stageId[MUL_LAT-1];
    assign rsp_data  = mul_dout;
    assign busy      = |stageV;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Self-checking bench for mul_share_arbiter with a behavioural pipelined
// multiplier and a response scoreboard.
module tb_mul_share_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int MUL_LAT = 1;

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*32-1:0] req_a;
    logic [NUM_REQ*32-1:0] req_b;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  mul_ce;
    logic [31:0]           mul_din0;
    logic [31:0]           mul_din1;
    logic [63:0]           mul_dout;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [63:0]           rsp_data;
    logic                  busy;

    int numChecks = 0;
    int numPass   = 0;

    typedef struct {
        int          id;
        logic [63:0] data;
    } exp_t;
    exp_t expQ[$];

    typedef struct {
        int          idx;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] expData;
    } vec_t;
    vec_t vecs[5];

    mul_share_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .mul_ce(mul_ce), .mul_din0(mul_din0), .mul_din1(mul_din1), .mul_dout(mul_dout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mulRef(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        sa = $signed({32'b0, a});
        sb = $signed({{32{b[31]}}, b});
        return sa * sb;
    endfunction

    // Behavioural multiplier: MUL_LAT register stages, stalled by ce.
    logic [63:0] mulPipe [MUL_LAT];
    always @(posedge clk) begin
        if (mul_ce) begin
            for (int i = MUL_LAT - 1; i > 0; i--) mulPipe[i] <= mulPipe[i-1];
            mulPipe[0] <= mulRef(mul_din0, mul_din1);
        end
    end
    assign mul_dout = mulPipe[MUL_LAT-1];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        numChecks++;
        if (act === exp) numPass++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic applyStimulus(input logic [NUM_REQ-1:0] v);
        @(posedge clk); #1;
        req_valid = v;
    endtask

    task automatic setOperands(input int idx, input logic [31:0] a, input logic [31:0] b);
        req_a[32*idx +: 32] = a;
        req_b[32*idx +: 32] = b;
    endtask

    task automatic waitDrain();
        int n = 0;
        while (expQ.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("drain_queue_empty", 64'(expQ.size()), 64'd0);
    endtask

    // Scoreboard: every response accepted by the consumer pops one expectation.
    always @(negedge clk) begin
        if (reset_n && rsp_valid && rsp_ready) begin
            if (expQ.size() == 0) begin
                numChecks++;
                $display("[TB] FAIL sb_unexpected_rsp: got id %0d data %h, expected none", rsp_id, rsp_data);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput("sb_rsp_id", 64'(rsp_id), 64'(e.id));
                checkOutput("sb_rsp_data", rsp_data, e.data);
            end
        end
    end

    initial begin
        int lat;
        logic [63:0] heldData;
        logic [ID_W-1:0] heldId;
        bit stallSeen;

        vecs[0] = '{0, 32'd3,         32'hFFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFA};
        vecs[1] = '{2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_0000_0001};
        vecs[2] = '{1, 32'h8000_0000, 32'h7FFF_FFFF, 64'h3FFF_FFFF_8000_0000};
        vecs[3] = '{1, 32'd0,         32'h1234_5678, 64'h0000_0000_0000_0000};
        vecs[4] = '{3, 32'h0000_0010, 32'h8000_0000, 64'hFFFF_FFF8_0000_0000};

        reset_n   = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        #2;
        checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_req_ready", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("post_reset_mul_ce", 64'(mul_ce), 64'd1);
        checkOutput("post_reset_din0", 64'(mul_din0), 64'd0);

        // Isolated single requests: grant, latency and product per vector.
        for (int i = 0; i < 5; i++) begin
            setOperands(vecs[i].idx, vecs[i].a, vecs[i].b);
            applyStimulus(NUM_REQ'(1) << vecs[i].idx);
            @(negedge clk);
            checkOutput($sformatf("vec%0d_grant", i), 64'(req_ready), 64'(NUM_REQ'(1) << vecs[i].idx));
            if (req_ready[vecs[i].idx]) expQ.push_back('{vecs[i].idx, vecs[i].expData});
            @(posedge clk); #1;
            req_valid = '0;
            lat = 1;
            while (!rsp_valid && lat < 8) begin
                @(posedge clk); #1;
                lat++;
            end
            checkOutput($sformatf("vec%0d_latency", i), 64'(lat), 64'(MUL_LAT));
            waitDrain();
        end

        // Round robin with all requesters active; last grant was 3.
        for (int i = 0; i < NUM_REQ; i++) setOperands(i, 32'(i + 1) * 32'd1000, $urandom);
        applyStimulus('1);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checkOutput($sformatf("rr_grant%0d", c), 64'(req_ready), 64'(NUM_REQ'(1) << (c % NUM_REQ)));
            for (int i = 0; i < NUM_REQ; i++)
                if (req_ready[i]) expQ.push_back('{i, mulRef(req_a[32*i +: 32], req_b[32*i +: 32])});
            @(posedge clk); #1;
        end
        req_valid = '0;
        waitDrain();

        // Sparse: 3 then 1 on consecutive cycles.
        setOperands(3, 32'd7, 32'hFFFF_FFF9);
        setOperands(1, 32'd11, 32'd13);
        applyStimulus(4'b1000);
        @(negedge clk);
        checkOutput("sparse_grant3", 64'(req_ready), 64'b1000);
        if (req_ready[3]) expQ.push_back('{3, 64'hFFFF_FFFF_FFFF_FFCF});
        @(posedge clk); #1;
        req_valid = 4'b0010;
        @(negedge clk);
        checkOutput("sparse_grant1", 64'(req_ready), 64'b0010);
        if (req_ready[1]) expQ.push_back('{1, 64'd143});
        @(posedge clk); #1;
        req_valid = '0;
        waitDrain();

        // Backpressure: stream from requester 1 with a 5-cycle consumer stall.
        stallSeen = 1'b0;
        heldData  = '0;
        heldId    = '0;
        req_valid = 4'b0010;
        for (int c = 0; c < 14; c++) begin
            setOperands(1, 32'd100 + 32'(c), 32'hFFFF_FF00 + 32'(c));
            rsp_ready = !(c >= 4 && c < 9);
            @(negedge clk);
            if (req_ready[1]) expQ.push_back('{1, mulRef(req_a[63:32], req_b[63:32])});
            if (!rsp_ready) begin
                checkOutput("bp_mul_ce", 64'(mul_ce), 64'd0);
                checkOutput("bp_req_ready", 64'(req_ready), 64'd0);
                checkOutput("bp_rsp_valid", 64'(rsp_valid), 64'd1);
                if (stallSeen) begin
                    checkOutput("bp_rsp_data_hold", rsp_data, heldData);
                    checkOutput("bp_rsp_id_hold", 64'(rsp_id), 64'(heldId));
                end
                stallSeen = 1'b1;
                heldData  = rsp_data;
                heldId    = rsp_id;
            end
            @(posedge clk); #1;
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        waitDrain();

        // Reset while operations are in flight.
        req_valid = 4'b0011;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            for (int i = 0; i < NUM_REQ; i++)
                if (req_ready[i]) expQ.push_back('{i, mulRef(req_a[32*i +: 32], req_b[32*i +: 32])});
            @(posedge clk); #1;
        end
        checkOutput("rst_busy_before", 64'(busy), 64'd1);
        reset_n   = 1'b0;
        req_valid = '1;
        #1;
        checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_req_ready", 64'(req_ready), 64'd0);
        expQ.delete();
        @(posedge clk);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_first_grant", 64'(req_ready), 64'b0001);
        checkOutput("rst_no_stale_rsp", 64'(rsp_valid), 64'd0);
        if (req_ready[0]) expQ.push_back('{0, mulRef(req_a[31:0], req_b[31:0])});
        @(posedge clk); #1;
        req_valid = '0;
        waitDrain();

        $display("[TB] %0d/%0d checks passed", numPass, numChecks);
        $finish;
    end

endmodule
